// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, status bit layout and default addresses for mmio_uart_tx
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam logic [7:0] DEF_TX_ADDR = 8'hFF;
  localparam logic [7:0] DEF_STATUS_ADDR = 8'hFE;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; full/empty derived from the occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped byte FIFO feeding an 8N1 serial transmitter with a pollable status word.
// Define UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] TX_ADDR = DEF_TX_ADDR,
  parameter logic [7:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  input  logic        wren,
  input  logic        rden,
  output logic [31:0] dout,
  output logic        txd,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift, head;
  logic par, ovf, full, empty, bit_end, pop, wr, acc, drop, st_rd, txd_n;
  logic [AW:0] count;
  logic [31:0] status;
  logic unused_din;
  assign unused_din = ^din[31:8];
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  assign wr = wren && addr == TX_ADDR;
  assign acc = wr && (!full || pop);
  assign drop = wr && !acc;
  assign st_rd = rden && addr == STATUS_ADDR;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clock), .rst(clear), .push(acc), .pop(pop), .wdata(din[7:0]),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pop ? START : IDLE;
      START:   state_n = bit_end ? DATA : START;
      DATA:    state_n = (bit_end && idx == 3'd7) ? AFTER_DATA : DATA;
      PARITY:  state_n = bit_end ? STOP : PARITY;
      STOP:    state_n = bit_end ? (pop ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    txd_n = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_ACTIVE] = state != IDLE;
    status[ST_OVF] = ovf;
    status[ST_COUNT_LSB +: 8] = 8'(count);
  end
  // txd is registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      par <= 1'b0;
      ovf <= 1'b0;
      txd <= 1'b1;
      busy <= 1'b0;
      dout <= '0;
    end else begin
      state <= state_n;
      txd <= txd_n;
      busy <= count != '0 || state != IDLE;
      cnt <= (pop || bit_end) ? '0 : cnt + 1'b1;
      if (pop) begin
        shift <= head;
        par <= ^head;
        idx <= '0;
      end else if (state == DATA && bit_end) begin
        shift <= shift >> 1;
        idx <= idx + 1'b1;
      end
      ovf <= drop || (ovf && !st_rd);
      if (rden) dout <= st_rd ? status : '0;
    end
  end
endmodule
